// File: rtl/servo_pwm_rx_pkg.sv
// Shared types and widths for the servo PWM receive monitor.
// State encoding is fixed so register-interface software can decode it.
package servo_pwm_rx_pkg;

   localparam int UI_W = 12;
   localparam int WD_W = 24;

   typedef enum logic [1:0] {
      ST_FAILSAFE = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } rx_state_t;

   // Inclusive window test; an inverted window (lo > hi) rejects everything.
   function automatic logic in_window(input logic [UI_W-1:0] ticks,
                                      input logic [UI_W-1:0] lo,
                                      input logic [UI_W-1:0] hi);
      return (ticks >= lo) && (ticks <= hi);
   endfunction

   function automatic logic [UI_W:0] centre_offset(input logic [UI_W-1:0] pos,
                                                   input logic [UI_W-1:0] centre);
      return {1'b0, pos} - {1'b0, centre};
   endfunction

endpackage

// File: rtl/servo_pwm_rx_monitor_if.sv
// Pulse-measurement stream in from the capture stage and held position out.
// The capture side is the master; the monitor is the slave.
interface servo_pwm_rx_monitor_if;
   import servo_pwm_rx_pkg::*;

   logic [UI_W-1:0] pwm_rx_ui_ticks;
   logic            pwm_rx_ui_ticks_dv;
   logic [UI_W-1:0] servo_pos;
   logic [UI_W:0]   servo_pos_signed;
   logic            servo_pos_dv;

   modport master (
      output pwm_rx_ui_ticks, pwm_rx_ui_ticks_dv,
      input  servo_pos, servo_pos_signed, servo_pos_dv
   );

   modport slave (
      input  pwm_rx_ui_ticks, pwm_rx_ui_ticks_dv,
      output servo_pos, servo_pos_signed, servo_pos_dv
   );

endinterface

// File: rtl/servo_pwm_rx_watchdog.sv
// Frame watchdog: counts enabled clocks since the last clear and pulses
// expire on the cycle the count reaches TIMEOUT_CLKS-1.
module servo_pwm_rx_watchdog
   import servo_pwm_rx_pkg::*;
#(
   parameter int TIMEOUT_CLKS = 2500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   localparam logic [WD_W-1:0] LAST_COUNT = WD_W'(TIMEOUT_CLKS - 1);

   logic [WD_W-1:0] count_reg;

   // A clear in the expiry cycle wins, so a late but valid pulse keeps the link.
   assign expire = enable && !clear && (count_reg == LAST_COUNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (!enable || clear || expire) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/servo_pwm_rx_monitor.sv
// Validates captured servo pulses, tracks lock, and drives a held position
// with failsafe substitution, link status and a saturating reject counter.
module servo_pwm_rx_monitor
   import servo_pwm_rx_pkg::*;
#(
   parameter int CONFIRM_N    = 3,
   parameter int MAX_BAD      = 4,
   parameter int TIMEOUT_CLKS = 2500000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   servo_pwm_rx_monitor_if.slave rx,
   input  logic [UI_W-1:0]       min_ui,
   input  logic [UI_W-1:0]       max_ui,
   input  logic [UI_W-1:0]       center_ui,
   input  logic [UI_W-1:0]       failsafe_ui,
   input  logic                  err_clr,
   output logic                  link_ok,
   output logic                  failsafe,
   output logic [7:0]            err_cnt
);

   localparam logic [3:0] CONFIRM_LAST = 4'(CONFIRM_N - 1);
   localparam logic [3:0] BAD_LAST     = 4'(MAX_BAD - 1);

   rx_state_t       state_reg;
   logic [3:0]      good_cnt_reg;
   logic [3:0]      bad_run_reg;
   logic [UI_W-1:0] servo_pos_reg;
   logic [UI_W:0]   servo_signed_reg;
   logic            servo_dv_reg;
   logic            link_ok_reg;
   logic            failsafe_reg;
   logic [7:0]      err_cnt_reg;
   logic [7:0]      err_cnt_next;

   logic [UI_W-1:0] ticks;
   logic            accepted;
   logic            rejected;
   logic            bad_limit;
   logic            timeout;

   assign ticks     = rx.pwm_rx_ui_ticks;
   assign accepted  = rx.pwm_rx_ui_ticks_dv && in_window(ticks, min_ui, max_ui);
   assign rejected  = rx.pwm_rx_ui_ticks_dv && !accepted;
   assign bad_limit = (state_reg == ST_LOCKED) && rejected && (bad_run_reg == BAD_LAST);

   servo_pwm_rx_watchdog #(
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) u_watchdog (
      .clk   (clk),
      .rst_n (rst_n),
      .enable(state_reg != ST_FAILSAFE),
      .clear (accepted || bad_limit),
      .expire(timeout)
   );

   // A clear that coincides with a rejection still counts that rejection.
   always_comb begin
      err_cnt_next = err_cnt_reg;
      if (err_clr) begin
         err_cnt_next = rejected ? 8'd1 : 8'd0;
      end else if (rejected && (err_cnt_reg != 8'hFF)) begin
         err_cnt_next = err_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= ST_FAILSAFE;
         good_cnt_reg     <= '0;
         bad_run_reg      <= '0;
         servo_pos_reg    <= '0;
         servo_signed_reg <= '0;
         servo_dv_reg     <= 1'b0;
         link_ok_reg      <= 1'b0;
         failsafe_reg     <= 1'b1;
         err_cnt_reg      <= '0;
      end else begin
         servo_dv_reg <= 1'b0;
         err_cnt_reg  <= err_cnt_next;
         case (state_reg)
            ST_FAILSAFE: begin
               if (accepted) begin
                  good_cnt_reg <= 4'd1;
                  failsafe_reg <= 1'b0;
                  if (CONFIRM_N == 1) begin
                     state_reg        <= ST_LOCKED;
                     link_ok_reg      <= 1'b1;
                     servo_pos_reg    <= ticks;
                     servo_signed_reg <= centre_offset(ticks, center_ui);
                     servo_dv_reg     <= 1'b1;
                  end else begin
                     state_reg <= ST_ACQUIRE;
                  end
               end
            end
            ST_ACQUIRE: begin
               if (timeout) begin
                  state_reg        <= ST_FAILSAFE;
                  servo_pos_reg    <= failsafe_ui;
                  servo_signed_reg <= centre_offset(failsafe_ui, center_ui);
                  servo_dv_reg     <= 1'b1;
                  good_cnt_reg     <= '0;
                  bad_run_reg      <= '0;
                  link_ok_reg      <= 1'b0;
                  failsafe_reg     <= 1'b1;
               end else if (accepted) begin
                  good_cnt_reg <= good_cnt_reg + 4'd1;
                  if (good_cnt_reg == CONFIRM_LAST) begin
                     state_reg        <= ST_LOCKED;
                     link_ok_reg      <= 1'b1;
                     bad_run_reg      <= '0;
                     servo_pos_reg    <= ticks;
                     servo_signed_reg <= centre_offset(ticks, center_ui);
                     servo_dv_reg     <= 1'b1;
                  end
               end else if (rejected) begin
                  good_cnt_reg <= '0;
               end
            end
            ST_LOCKED: begin
               if (timeout || bad_limit) begin
                  state_reg        <= ST_FAILSAFE;
                  servo_pos_reg    <= failsafe_ui;
                  servo_signed_reg <= centre_offset(failsafe_ui, center_ui);
                  servo_dv_reg     <= 1'b1;
                  good_cnt_reg     <= '0;
                  bad_run_reg      <= '0;
                  link_ok_reg      <= 1'b0;
                  failsafe_reg     <= 1'b1;
               end else if (accepted) begin
                  servo_pos_reg    <= ticks;
                  servo_signed_reg <= centre_offset(ticks, center_ui);
                  servo_dv_reg     <= 1'b1;
                  bad_run_reg      <= '0;
               end else if (rejected) begin
                  bad_run_reg <= bad_run_reg + 4'd1;
               end
            end
            default: begin
               state_reg        <= ST_FAILSAFE;
               servo_pos_reg    <= failsafe_ui;
               servo_signed_reg <= centre_offset(failsafe_ui, center_ui);
               servo_dv_reg     <= 1'b1;
               good_cnt_reg     <= '0;
               bad_run_reg      <= '0;
               link_ok_reg      <= 1'b0;
               failsafe_reg     <= 1'b1;
            end
         endcase
      end
   end

   assign rx.servo_pos        = servo_pos_reg;
   assign rx.servo_pos_signed = servo_signed_reg;
   assign rx.servo_pos_dv     = servo_dv_reg;
   assign link_ok             = link_ok_reg;
   assign failsafe            = failsafe_reg;
   assign err_cnt             = err_cnt_reg;

endmodule

// File: tb/tb_servo_pwm_rx_monitor.sv
// Directed bench: stimulus pushes expected position updates into a queue,
// a negedge monitor pops and compares on every servo_pos_dv.
module tb_servo_pwm_rx_monitor;
   import servo_pwm_rx_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] min_ui = 12'd100;
   logic [11:0] max_ui = 12'd200;
   logic [11:0] center_ui = 12'd150;
   logic [11:0] failsafe_ui = 12'd150;
   logic        err_clr = 1'b0;
   logic        link_ok;
   logic        failsafe;
   logic [7:0]  err_cnt;

   typedef struct {
      logic [11:0] pos;
      logic [12:0] spos;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;

   servo_pwm_rx_monitor_if rx_if ();

   servo_pwm_rx_monitor #(
      .CONFIRM_N   (3),
      .MAX_BAD     (4),
      .TIMEOUT_CLKS(1000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx_if),
      .min_ui     (min_ui),
      .max_ui     (max_ui),
      .center_ui  (center_ui),
      .failsafe_ui(failsafe_ui),
      .err_clr    (err_clr),
      .link_ok    (link_ok),
      .failsafe   (failsafe),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic expect_pos(input int pos, input int spos);
      exp_t e;
      e.pos  = 12'(pos);
      e.spos = 13'(spos);
      exp_q.push_back(e);
   endtask

   // Called at a negedge; dv is sampled at the following posedge.
   task automatic send(input int t);
      rx_if.pwm_rx_ui_ticks    = 12'(t);
      rx_if.pwm_rx_ui_ticks_dv = 1'b1;
      @(negedge clk);
      rx_if.pwm_rx_ui_ticks_dv = 1'b0;
   endtask

   task automatic status(input string name, input int lk, input int fs);
      check({name, ".link_ok"}, int'(link_ok), lk);
      check({name, ".failsafe"}, int'(failsafe), fs);
   endtask

   task automatic check_reset(input string name);
      check({name, ".servo_pos"}, int'(rx_if.servo_pos), 0);
      check({name, ".signed"}, int'(rx_if.servo_pos_signed), 0);
      check({name, ".dv"}, int'(rx_if.servo_pos_dv), 0);
      status(name, 0, 1);
      check({name, ".err_cnt"}, int'(err_cnt), 0);
   endtask

   task automatic lock120(input string name);
      send(120);
      send(120);
      expect_pos(120, -30);
      send(120);
      status(name, 1, 0);
   endtask

   task automatic four_bad(input string name);
      send(50);
      send(50);
      send(50);
      status({name, ".3rd"}, 1, 0);
      expect_pos(150, 0);
      send(50);
      status(name, 0, 1);
   endtask

   always @(negedge clk) begin
      if (rst_n && rx_if.servo_pos_dv) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL servo_dv: unexpected update pos=%0d signed=%0d",
                     rx_if.servo_pos, rx_if.servo_pos_signed);
         end else begin
            mon_e = exp_q.pop_front();
            if (rx_if.servo_pos !== mon_e.pos || rx_if.servo_pos_signed !== mon_e.spos) begin
               bad++;
               $display("FAIL servo_update: got pos=%0d signed=0x%h expected pos=%0d signed=0x%h",
                        rx_if.servo_pos, rx_if.servo_pos_signed, mon_e.pos, mon_e.spos);
            end else begin
               $display("update pos=%0d signed=0x%h", rx_if.servo_pos, rx_if.servo_pos_signed);
            end
         end
      end
   end

   initial begin
      rx_if.pwm_rx_ui_ticks    = '0;
      rx_if.pwm_rx_ui_ticks_dv = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Acquire and lock
      send(120);
      status("acq1", 0, 0);
      send(120);
      expect_pos(120, -30);
      send(120);
      status("lock", 1, 0);

      // Locked tracking, rejections and inclusive window edges
      expect_pos(180, 30);
      send(180);
      send(250);
      send(90);
      expect_pos(181, 31);
      send(181);
      expect_pos(100, -50);
      send(100);
      expect_pos(200, 50);
      send(200);
      check("err_after_two_rejects", int'(err_cnt), 2);
      status("locked_track", 1, 0);

      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_clr_alone", int'(err_cnt), 0);
      four_bad("bad_run_fs");
      check("err_after_bad_run", int'(err_cnt), 4);

      // Watchdog expiry exactly 1000 clocks after the last accepted pulse
      lock120("relock1");
      repeat (999) @(negedge clk);
      status("wd_999", 1, 0);
      expect_pos(150, 0);
      @(negedge clk);
      status("wd_1000", 0, 1);

      // Accepted pulse on the expiry cycle keeps the lock
      lock120("relock2");
      repeat (999) @(negedge clk);
      expect_pos(160, 10);
      send(160);
      status("wd_pulse_wins", 1, 0);
      repeat (5) @(negedge clk);
      status("wd_pulse_wins_later", 1, 0);

      four_bad("bad_run_fs2");
      check("err_after_bad_run2", int'(err_cnt), 8);

      // Inverted window rejects everything
      min_ui = 12'd160;
      max_ui = 12'd140;
      send(150);
      check("err_inverted_window", int'(err_cnt), 9);
      status("inverted_window", 0, 1);
      min_ui = 12'd100;
      max_ui = 12'd200;

      // ACQUIRE restarts its count on a rejection
      send(120);
      status("acq_a", 0, 0);
      send(120);
      send(300);
      check("err_acq_reject", int'(err_cnt), 10);
      send(120);
      send(120);
      status("acq_no_lock", 0, 0);
      expect_pos(120, -30);
      send(120);
      status("acq_lock", 1, 0);

      // Saturation
      four_bad("bad_run_fs3");
      check("err_before_sat", int'(err_cnt), 14);
      for (int i = 0; i < 250; i++) send(300);
      check("err_saturated", int'(err_cnt), 255);
      send(300);
      check("err_held_255", int'(err_cnt), 255);

      err_clr = 1'b1;
      send(300);
      err_clr = 1'b0;
      check("err_clr_with_reject", int'(err_cnt), 1);

      // Asynchronous reset in the middle of LOCKED
      lock120("relock3");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("pending_updates", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/servo_pwm_rx_monitor.md
Name: servo_pwm_rx_monitor

Overview:
- Sits directly downstream of the PWM pulse-capture stage and consumes its per-pulse UI-tick measurement and data-valid strobe.
- Validates each pulse against a configurable window and confirms lock after N consecutive good pulses.
- Runs a frame watchdog and forces a configurable failsafe position on loss of signal or repeated bad pulses.
- Outputs a held servo position, unsigned and signed (centre-relative), plus link status and a saturating error counter for the register interface.

Parameters:
- CONFIRM_N, 3: consecutive in-window pulses required to enter LOCKED (1..15).
- MAX_BAD, 4: consecutive out-of-window pulses in LOCKED that force FAILSAFE (1..15).
- TIMEOUT_CLKS, 2500000: clocks without an accepted pulse before FAILSAFE (24-bit counter).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pwm_rx_ui_ticks  in  12  measured pulse width in UI ticks
- pwm_rx_ui_ticks_dv  in  1  one-cycle strobe; pwm_rx_ui_ticks valid this cycle
- min_ui  in  12  lowest acceptable width, inclusive
- max_ui  in  12  highest acceptable width, inclusive
- center_ui  in  12  neutral width used for the signed output
- failsafe_ui  in  12  position driven while in FAILSAFE
- err_clr  in  1  one-cycle pulse; clears err_cnt
- servo_pos  out  12  held position in UI ticks
- servo_pos_signed  out  13  servo_pos minus center_ui, two's complement
- servo_pos_dv  out  1  one-cycle strobe on every servo_pos update
- link_ok  out  1  high only in LOCKED
- failsafe  out  1  high only in FAILSAFE
- err_cnt  out  8  saturating count of rejected pulses

Behaviour:
- Reset (async assert, sync release): state=FAILSAFE, servo_pos=0, servo_pos_signed=0, servo_pos_dv=0, link_ok=0, failsafe=1, err_cnt=0, good_cnt=0, bad_run=0, watchdog=0.
- Accept test (combinational, on dv): min_ui <= ticks <= max_ui.
  - If min_ui > max_ui, every pulse is rejected.
  - Config inputs are sampled on the dv cycle only; changes take effect from the next pulse.
- Latency: all outputs are registered. An accepted pulse with dv in cycle N gives servo_pos and servo_pos_dv in cycle N+1.
- Signed output: servo_pos_signed = {1'b0,servo_pos} - {1'b0,center_ui} at 13 bits. It is registered together with servo_pos, using center_ui from the update cycle.
- Watchdog:
  - Counts clocks in ACQUIRE and LOCKED; held at 0 in FAILSAFE.
  - Cleared by an accepted pulse.
  - Expires when count = TIMEOUT_CLKS-1.
  - If an accepted pulse and expiry occur in the same cycle, the pulse wins: no timeout.
- State machine:
  - FAILSAFE, accepted pulse: good_cnt=1; go to ACQUIRE, or to LOCKED if CONFIRM_N=1. Rejected pulse: err_cnt++ and stay.
  - ACQUIRE, accepted pulse: good_cnt++; on reaching CONFIRM_N go to LOCKED and update servo_pos with this pulse.
  - ACQUIRE, rejected pulse: good_cnt=0, err_cnt++, stay.
  - ACQUIRE, timeout: go to FAILSAFE.
  - LOCKED, accepted pulse: update servo_pos, servo_pos_dv=1, bad_run=0.
  - LOCKED, rejected pulse: servo_pos held, err_cnt++, bad_run++. When bad_run reaches MAX_BAD, go to FAILSAFE.
  - LOCKED, timeout: go to FAILSAFE.
- On entry to FAILSAFE (not at reset):
  - servo_pos=failsafe_ui and servo_pos_dv pulses once.
  - good_cnt=0, bad_run=0.
  - servo_pos is not refreshed if failsafe_ui later changes while in FAILSAFE.
- No servo_pos update occurs in ACQUIRE before confirmation.
- err_cnt saturates at 255.
  - err_clr alone sets it to 0.
  - err_clr together with a rejection sets it to 1.
- link_ok and failsafe are decoded registered from state; both are 0 in ACQUIRE.
- dv strobes less than 2 cycles apart need no special handling: each is processed independently.

Decomposition:
- Shared package/header servo_pwm_rx_pkg holds:
  - state encoding (FAILSAFE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2)
  - UI width constant (12)
  - watchdog width (24)
- One sub-module, servo_pwm_rx_watchdog: parameterised TIMEOUT_CLKS, inputs enable/clear, output expire pulse.

Test Plan (bench params CONFIRM_N=3, MAX_BAD=4, TIMEOUT_CLKS=1000; min=100, max=200, center=150, failsafe=150):
- Reset, then three dv pulses of 120 -> LOCKED after the 3rd; servo_pos=120 and signed=-30 one cycle after the 3rd dv; link_ok=1; exactly one servo_pos_dv.
- LOCKED, pulses 180, 250, 90, 181 -> servo_pos 180 then 181; err_cnt=2; state stays LOCKED.
- LOCKED, four consecutive pulses of 50 -> FAILSAFE after the 4th; servo_pos=150 with one dv pulse; failsafe=1; err_cnt=4.
- LOCKED, no dv for 1000 clocks -> FAILSAFE exactly at clock 1000. Repeat with an accepted dv on the expiry cycle -> stays LOCKED.
- ACQUIRE sequence 120, 120, 300, 120 -> no lock: good_cnt resets; lock requires 3 more goods; no servo_pos_dv before lock.
- err_cnt driven past 255 -> holds at 255; err_clr coinciding with a rejection -> err_cnt=1; rst_n asserted mid-LOCKED -> all outputs at reset values immediately, asynchronously.
